// File: rtl/blender_pkg.sv
// Shared opcodes, core timing constants and the command-driver FSM state type
// for the blender pixel pipeline.
package blender_pkg;

  localparam logic [3:0] OP_NOP     = 4'b0000;
  localparam logic [3:0] OP_BLEND_5 = 4'b0101;
  localparam logic [3:0] OP_BLEND_D = 4'b1101;
  localparam logic [3:0] OP_BLEND_A = 4'b1010;
  localparam logic [3:0] OP_BLEND_9 = 4'b1001;
  localparam logic [3:0] OP_BLEND_E = 4'b1110;
  localparam logic [3:0] OP_BLEND_F = 4'b1111;

  localparam int          BL_LAT    = 6;
  localparam logic [31:0] BL_OFFSET = 32'd123522;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRIME,
    ST_ISSUE,
    ST_HOLD
  } drv_state_e;

endpackage

// File: rtl/blender_rsp_fifo.sv
// Synchronous response FIFO with first-word fall-through read and an occupancy count.
module blender_rsp_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid    = (count != '0);
  assign do_pop   = pop & valid;
  assign do_push  = push & ((count != FULL) | do_pop);
  // Head entry is read combinationally so rsp_valid and data appear together.
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/blender_cmd_driver.sv
// Command-side initiator for the blender core: sequences op/operands with the core's
// operation-before-operand timing, gates its clock, and returns tagged results.
module blender_cmd_driver
  import blender_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             bl_clk_enable,
  output logic             bl_test_mode,
  output logic [3:0]       bl_operation,
  output logic [31:0]      bl_op1,
  output logic [31:0]      bl_op2,
  input  logic [31:0]      bl_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int            CNT_W     = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W+1)'(RSP_DEPTH);

  drv_state_e       state, state_next;
  logic             ready_en;
  logic             pend_valid;
  logic [3:0]       pend_op;
  logic [31:0]      pend_a, pend_b;
  logic [TAG_W-1:0] pend_tag;
  logic [TAG_W-1:0] issue_tag;
  logic             hold_cnt;
  logic             load_op, take, credit_ok, accept;
  logic [CNT_W:0]   used;
  logic [CNT_W-1:0] fifo_count;
  logic [BL_LAT-1:0] trk_valid;
  logic [TAG_W-1:0] trk_tag [BL_LAT];
  logic [31+TAG_W:0] fifo_out;

  // Ready also while the pending entry is being issued, so same-op commands stream 1/cycle.
  assign cmd_ready    = ready_en & (~pend_valid | take);
  assign accept       = cmd_valid & cmd_ready;
  assign bl_test_mode = 1'b0;
  assign {rsp_result, rsp_tag} = fifo_out;
  assign busy = pend_valid | (state != ST_IDLE) | (|trk_valid) | rsp_valid;

  // Every outstanding command counted once: operands registered, in tracker, or in FIFO.
  always_comb begin
    used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (state == ST_ISSUE)};
    for (int i = 0; i < BL_LAT; i++) used = used + {{CNT_W{1'b0}}, trk_valid[i]};
    credit_ok = (used < DEPTH_LIM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    take       = 1'b0;
    case (state)
      ST_IDLE: if (pend_valid) begin
        load_op    = 1'b1;
        state_next = ST_PRIME;
      end
      ST_PRIME: if (pend_valid && credit_ok) begin
        take       = 1'b1;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (pend_valid && (pend_op == bl_operation) && credit_ok) take = 1'b1;
        else state_next = ST_HOLD;
      end
      ST_HOLD: if (hold_cnt) begin
        if (pend_valid) begin
          load_op    = 1'b1;
          state_next = ST_PRIME;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en      <= 1'b0;
      pend_valid    <= 1'b0;
      pend_op       <= '0;
      pend_a        <= '0;
      pend_b        <= '0;
      pend_tag      <= '0;
      bl_operation  <= '0;
      bl_op1        <= '0;
      bl_op2        <= '0;
      issue_tag     <= '0;
      hold_cnt      <= 1'b0;
      bl_clk_enable <= 1'b0;
      trk_valid     <= '0;
      trk_tag[0]    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        pend_valid <= 1'b1;
        pend_op    <= cmd_op;
        pend_a     <= cmd_a;
        pend_b     <= cmd_b;
        pend_tag   <= cmd_tag;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
      if (load_op) bl_operation <= pend_op;
      if (take) begin
        bl_op1    <= pend_a;
        bl_op2    <= pend_b;
        issue_tag <= pend_tag;
      end
      hold_cnt <= (state == ST_HOLD) ? ~hold_cnt : 1'b0;
      // Keep the core clocked until the last valid slot has reached the result stage.
      bl_clk_enable <= (state_next != ST_IDLE) | (|trk_valid[BL_LAT-2:0]);
      trk_valid     <= {trk_valid[BL_LAT-2:0], (state == ST_ISSUE)};
      trk_tag[0]    <= issue_tag;
    end
  end

  generate
    for (genvar gi = 1; gi < BL_LAT; gi++) begin : g_trk
      always_ff @(posedge clk or posedge reset) begin
        if (reset) trk_tag[gi] <= '0;
        else       trk_tag[gi] <= trk_tag[gi-1];
      end
    end
  endgenerate

  blender_rsp_fifo #(
    .W     (32 + TAG_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (trk_valid[BL_LAT-1]),
    .push_data ({bl_result, trk_tag[BL_LAT-1]}),
    .pop       (rsp_ready),
    .pop_data  (fifo_out),
    .valid     (rsp_valid),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_blender_cmd_driver.sv
// Bench for blender_cmd_driver: behavioural blender core plus an in-order scoreboard
// of expected {result, tag}, directed timing scenarios and randomized traffic.
module tb_blender_cmd_driver;
  import blender_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_tag;
  logic        bl_clk_enable, bl_test_mode;
  logic [3:0]  bl_operation;
  logic [31:0] bl_op1, bl_op2, bl_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_tag;
  logic        busy;

  blender_cmd_driver #(.TAG_W(4), .RSP_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .bl_clk_enable(bl_clk_enable), .bl_test_mode(bl_test_mode),
    .bl_operation(bl_operation), .bl_op1(bl_op1), .bl_op2(bl_op2),
    .bl_result(bl_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_tag(rsp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  // Blend function of the modelled core.
  function automatic logic [31:0] core_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      OP_NOP:     r = a + b;
      OP_BLEND_9: r = a + b - 32'd16;
      OP_BLEND_5: r = a - b;
      OP_BLEND_D: r = a & b;
      OP_BLEND_A: r = a | b;
      OP_BLEND_E: r = a ^ b;
      default:    r = a + (b << 1);
    endcase
    return BL_OFFSET + r;
  endfunction

  // Core model: samples operands on every gated edge; the operation must hold from the
  // edge before sampling to two edges after, otherwise the result is corrupted.
  logic [31:0] pa [6];
  logic [31:0] pb [6];
  logic [3:0]  po [6];
  logic        pk [6];
  logic [3:0]  op_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      op_prev <= '0;
      for (int k = 0; k < 6; k++) begin
        pa[k] <= '0; pb[k] <= '0; po[k] <= '0; pk[k] <= 1'b0;
      end
    end else if (bl_clk_enable) begin
      op_prev <= bl_operation;
      pa[0] <= bl_op1; pb[0] <= bl_op2; po[0] <= bl_operation;
      pk[0] <= (bl_operation == op_prev);
      for (int k = 1; k < 6; k++) begin
        pa[k] <= pa[k-1]; pb[k] <= pb[k-1]; po[k] <= po[k-1];
        pk[k] <= pk[k-1] & ((k > 2) || (bl_operation == po[k-1]));
      end
    end
  end

  assign bl_result = pk[5] ? core_fn(po[5], pa[5], pb[5]) : 32'hDEADBEEF;

  // Scoreboard and monitor: handshakes observed at negedge complete on the next posedge.
  typedef struct { logic [31:0] res; logic [3:0] tag; } exp_t;
  exp_t        exp_q[$];
  int          rsp_edges[$];
  logic [31:0] rsp_vals[$];
  int          cyc = 0;
  int          acc_cnt = 0, rsp_cnt = 0, last_acc_edge = 0;
  logic [31:0] last_res;
  logic [3:0]  last_tag;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.res = core_fn(cmd_op, cmd_a, cmd_b);
        e.tag = cmd_tag;
        exp_q.push_back(e);
        acc_cnt++;
        last_acc_edge = cyc + 1;
      end
      if (rsp_valid && rsp_ready) begin
        $display("rsp  edge=%0d tag=%0d result=%0d", cyc, rsp_tag, rsp_result);
        check("rsp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_result", rsp_result, e.res);
          check("rsp_tag", rsp_tag, e.tag);
        end
        rsp_edges.push_back(cyc);
        rsp_vals.push_back(rsp_result);
        last_res = rsp_result;
        last_tag = rsp_tag;
        rsp_cnt++;
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    int n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = t;
    @(negedge clk);
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    check("send_accepted", cmd_ready, 1'b1);
    $display("cmd  op=%b a=%0d b=%0d tag=%0d", op, a, b, t);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n = 0;
    while (rsp_cnt < target && n < budget) begin @(negedge clk); n++; end
    check("rsp_arrived", rsp_cnt >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin @(negedge clk); n++; end
    check("idle_reached", busy, 1'b0);
    @(posedge clk); #1;
  endtask

  logic [3:0] op_set [7];
  logic       rnd_done;

  initial begin
    int base, acc0, last_acc;
    logic [3:0] op;
    op_set = '{OP_NOP, OP_BLEND_5, OP_BLEND_D, OP_BLEND_A, OP_BLEND_9, OP_BLEND_E, OP_BLEND_F};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    rsp_ready = 1'b1; rnd_done = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_clk_enable", bl_clk_enable, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_operation", bl_operation, 4'd0);
    check("rst_test_mode", bl_test_mode, 1'b0);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Single NOP: latency from accept edge to rsp_valid is 9
    rsp_edges.delete(); base = rsp_cnt;
    send(OP_NOP, 0, 0, 4'd5);
    last_acc = last_acc_edge;
    wait_rsp(base + 1, 40);
    check("nop_result", last_res, 32'd123522);
    check("nop_tag", last_tag, 4'd5);
    if (rsp_edges.size() > 0) check("nop_latency", rsp_edges[0] - last_acc, 9);
    wait_idle();
    check("idle_clk_enable", bl_clk_enable, 1'b0);

    // trans3
    base = rsp_cnt;
    send(OP_BLEND_9, 100, 50, 4'd3);
    wait_rsp(base + 1, 40);
    check("trans3_result", last_res, 32'd123656);
    wait_idle();

    // Same-op streaming
    rsp_edges.delete(); rsp_vals.delete(); base = rsp_cnt;
    for (int i = 1; i <= 4; i++) send(OP_NOP, i, 2 * i, 4'(i));
    wait_rsp(base + 4, 60);
    for (int i = 0; i < 4 && i < rsp_vals.size(); i++)
      check("stream_value", rsp_vals[i], 32'(123522 + 3 * (i + 1)));
    for (int i = 1; i < 4 && i < rsp_edges.size(); i++)
      check("stream_gap", rsp_edges[i] - rsp_edges[i-1], 1);
    wait_idle();

    // Op change spacing
    rsp_edges.delete(); base = rsp_cnt;
    send(OP_NOP, 7, 8, 4'd1);
    send(OP_BLEND_9, 9, 10, 4'd2);
    wait_rsp(base + 2, 60);
    if (rsp_edges.size() > 1) check("opchange_gap", rsp_edges[1] - rsp_edges[0], 4);
    wait_idle();

    // Backpressure: credit limit stalls command intake
    rsp_ready = 1'b0; base = rsp_cnt; acc0 = acc_cnt;
    fork
      for (int i = 0; i < 10; i++)
        send((i < 5) ? OP_BLEND_5 : OP_BLEND_F, $urandom, $urandom, 4'(i));
      begin
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("bp_accepted", acc_cnt - acc0, 9);
        check("bp_cmd_ready", cmd_ready, 1'b0);
        check("bp_no_rsp", rsp_cnt - base, 0);
        check("bp_busy", busy, 1'b1);
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    wait_rsp(base + 10, 200);
    check("bp_drained", rsp_cnt - base, 10);
    wait_idle();

    // Randomized traffic with random response backpressure
    base = rsp_cnt; op = OP_NOP;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 2) != 0) op = op_set[$urandom_range(0, 6)];
          send(op, $urandom, $urandom, 4'($urandom));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
        rnd_done = 1'b1;
      end
      while (!rnd_done) begin
        @(posedge clk); #1 rsp_ready = ($urandom_range(0, 3) != 0);
      end
    join
    rsp_ready = 1'b1;
    wait_rsp(base + 40, 400);
    check("rnd_count", rsp_cnt - base, 40);
    wait_idle();

    // Reset three cycles after the issue edge discards the in-flight command
    base = rsp_cnt;
    send(OP_BLEND_E, 32'h1234, 32'h0F0F, 4'd9);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_clk_enable", bl_clk_enable, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt - base, 0);
    check("midrst_busy_after", busy, 1'b0);
    check("midrst_clk_enable_after", bl_clk_enable, 1'b0);
    @(posedge clk); #1;

    // Recovery after reset
    base = rsp_cnt;
    send(OP_NOP, 1, 1, 4'd14);
    wait_rsp(base + 1, 40);
    check("recover_result", last_res, 32'd123524);
    wait_idle();
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
